// File: rtl/scanner_link_rx.sv
// Receiver for the scanner serial link: deserialises LSB-first bytes,
// decodes command frames, and queues the data byte that follows cmd 7
// into a small first-word-fall-through FIFO.
module scanner_link_rx #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ser_clk,
    input  logic                          ser_data,
    output logic                          ready_for_transfer,
    output logic                          cmd_valid,
    output logic [7:0]                    cmd_code,
    output logic                          data_valid,
    output logic [7:0]                    data_out,
    input  logic                          data_ready,
    output logic                          frame_err,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [7:0]    TIMEOUT_C = 8'(TIMEOUT);

    typedef enum logic [1:0] {RX_CMD, RX_DATA, ABORT} state_t;

    state_t          state, state_n;
    logic            ser_clk_p0, ser_clk_p1, ser_clk_p2;
    logic            ser_data_p0, ser_data_p1;
    logic            rise_p1;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic [7:0]      idle_cnt;
    logic            frame_done;
    logic [7:0]      frame_byte;
    logic            timeout;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            full, pop, push;
    logic            cmd_valid_n, frame_err_n, overflow_n;
    logic [7:0]      cmd_code_n;

    function automatic logic known_cmd(input logic [7:0] c);
        return (c == 8'd2) || (c == 8'd3) || (c == 8'd4);
    endfunction

    // Synchroniser stage: ser_clk/ser_data into clk domain, plus delayed clock copy
    always_ff @(posedge clk) begin
        ser_clk_p0  <= ser_clk;
        ser_clk_p1  <= ser_clk_p0;
        ser_clk_p2  <= ser_clk_p1;
        ser_data_p0 <= ser_data;
        ser_data_p1 <= ser_data_p0;
    end

    assign rise_p1    = ser_clk_p1 & ~ser_clk_p2;
    assign frame_done = rise_p1 && (bit_cnt == 3'd7) && (state != ABORT);
    assign frame_byte = {ser_data_p1, shreg[6:0]};
    assign timeout    = (idle_cnt == TIMEOUT_C) && ((bit_cnt != 3'd0) || (state == RX_DATA));

    // Bit counter: advances on each link clock rise, cleared by reset or abort
    always_ff @(posedge clk) begin
        if (rst || state == ABORT)
            bit_cnt <= 3'd0;
        else if (rise_p1)
            bit_cnt <= bit_cnt + 3'd1;
    end

    // Shift register: each rise writes one bit position, LSB first
    always_ff @(posedge clk) begin
        if (state == ABORT)
            shreg <= 8'h00;
        else if (rise_p1)
            shreg[bit_cnt] <= ser_data_p1;
    end

    // Idle counter: counts clk cycles between rises while a frame or data byte is pending
    always_ff @(posedge clk) begin
        if (rst || state == ABORT || rise_p1 || (bit_cnt == 3'd0 && state != RX_DATA))
            idle_cnt <= 8'd0;
        else if (idle_cnt != 8'hFF)
            idle_cnt <= idle_cnt + 8'd1;
    end

    // FSM state and registered decode outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RX_CMD;
            cmd_valid <= 1'b0;
            cmd_code  <= 8'h00;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_n;
            cmd_valid <= cmd_valid_n;
            cmd_code  <= cmd_code_n;
            frame_err <= frame_err_n;
            overflow  <= overflow_n;
        end
    end

    // FSM next-state and decode: frame completion wins over a coincident timeout
    always_comb begin
        state_n     = state;
        cmd_valid_n = 1'b0;
        cmd_code_n  = cmd_code;
        frame_err_n = 1'b0;
        overflow_n  = 1'b0;
        push        = 1'b0;
        case (state)
            RX_CMD: begin
                if (frame_done) begin
                    if (known_cmd(frame_byte)) begin
                        cmd_valid_n = 1'b1;
                        cmd_code_n  = frame_byte;
                    end else if (frame_byte == 8'd7) begin
                        cmd_valid_n = 1'b1;
                        cmd_code_n  = frame_byte;
                        state_n     = RX_DATA;
                    end else begin
                        frame_err_n = 1'b1;
                    end
                end else if (timeout) begin
                    state_n = ABORT;
                end
            end
            RX_DATA: begin
                if (frame_done) begin
                    if (full && !pop)
                        overflow_n = 1'b1;
                    else
                        push = 1'b1;
                    state_n = RX_CMD;
                end else if (timeout) begin
                    state_n = ABORT;
                end
            end
            ABORT: begin
                frame_err_n = 1'b1;
                state_n     = RX_CMD;
            end
            default: state_n = RX_CMD;
        endcase
    end

    assign full       = (count == DEPTH_C);
    assign pop        = (count != '0) && data_ready;
    assign data_valid = (count != '0);
    assign data_out   = data_valid ? mem[rd_ptr] : 8'h00;
    assign fifo_count = count;

    // FIFO storage: written on push only
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= frame_byte;
    end

    // FIFO pointers and occupancy; simultaneous push/pop leaves count unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Flow control back to the scanner, one cycle behind occupancy
    always_ff @(posedge clk) begin
        if (rst)
            ready_for_transfer <= 1'b0;
        else
            ready_for_transfer <= (count < DEPTH_C);
    end

endmodule
